// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the saturating two's-complement negate.
// Pure package: no state, no latency.
package cordic_pkg;

    localparam logic MODE_VEC = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    // Widest datapath the negate helper supports; callers sign-extend into it.
    localparam int SAT_W = 64;

    typedef logic cordic_mode_t;

    // Negate a value that lives in the low w bits (sign-extended to SAT_W).
    // The most negative w-bit value maps to the most positive one instead of wrapping.
    function automatic logic signed [SAT_W-1:0] sat_neg(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        min_v = -(64'sd1 <<< (w - 1));
        if (v == min_v) begin
            res = ~min_v;
        end else begin
            res = -v;
        end
        return res;
    endfunction

endpackage

// File: rtl/cordic_vecrot_pipe_if.sv
// Beat-level handshake bundle for the CORDIC core: input beat, output beat, ready/valid.
// master = beat producer/consumer around the core, slave = the core itself.
interface cordic_vecrot_pipe_if #(
    parameter int CORDIC_WIDTH = 22,
    parameter int NUM_STAGES   = 16
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic                           mode_in;
    logic signed [CORDIC_WIDTH-1:0] x_in;
    logic signed [CORDIC_WIDTH-1:0] y_in;
    logic [NUM_STAGES:0]            dir_in;

    logic                           out_valid;
    logic                           out_ready;
    logic                           mode_out;
    logic signed [CORDIC_WIDTH-1:0] x_out;
    logic signed [CORDIC_WIDTH-1:0] y_out;
    logic [NUM_STAGES:0]            dir_out;

    modport master (
        output in_valid, mode_in, x_in, y_in, dir_in, out_ready,
        input  in_ready, out_valid, mode_out, x_out, y_out, dir_out
    );

    modport slave (
        input  in_valid, mode_in, x_in, y_in, dir_in, out_ready,
        output in_ready, out_valid, mode_out, x_out, y_out, dir_out
    );

endinterface

// File: rtl/cordic_micro_stage.sv
// One registered CORDIC micro-rotation by 2^-SHIFT; 1 cycle latency.
// Loads only when adv_i is high, otherwise holds its slot unchanged.
module cordic_micro_stage
    import cordic_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int SHIFT        = 0,
    parameter int NUM_STAGES   = 16
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           adv_i,
    input  logic                           vld_i,
    input  logic                           mode_i,
    input  logic signed [CORDIC_WIDTH-1:0] x_i,
    input  logic signed [CORDIC_WIDTH-1:0] y_i,
    input  logic [NUM_STAGES:0]            dir_i,
    output logic                           vld_o,
    output logic                           mode_o,
    output logic signed [CORDIC_WIDTH-1:0] x_o,
    output logic signed [CORDIC_WIDTH-1:0] y_o,
    output logic [NUM_STAGES:0]            dir_o
);

    logic                           d;
    logic signed [CORDIC_WIDTH-1:0] x_sh;
    logic signed [CORDIC_WIDTH-1:0] y_sh;
    logic signed [CORDIC_WIDTH-1:0] x_d;
    logic signed [CORDIC_WIDTH-1:0] y_d;
    logic [NUM_STAGES:0]            dir_d;

    logic                           vld_q;
    logic                           mode_q;
    logic signed [CORDIC_WIDTH-1:0] x_q;
    logic signed [CORDIC_WIDTH-1:0] y_q;
    logic [NUM_STAGES:0]            dir_q;

    // Vectoring picks d from the sign of y and records it; rotation replays the stored bit.
    always_comb begin
        d            = (mode_i == MODE_ROT) ? dir_i[SHIFT] : y_i[CORDIC_WIDTH-1];
        dir_d        = dir_i;
        dir_d[SHIFT] = d;
        x_sh         = x_i >>> SHIFT;
        y_sh         = y_i >>> SHIFT;
        if (d) begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
        end else begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_q  <= 1'b0;
            mode_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            dir_q  <= '0;
        end else if (adv_i) begin
            vld_q  <= vld_i;
            mode_q <= mode_i;
            x_q    <= x_d;
            y_q    <= y_d;
            dir_q  <= dir_d;
        end
    end

    assign vld_o  = vld_q;
    assign mode_o = mode_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign dir_o  = dir_q;

endmodule

// File: rtl/cordic_vecrot_pipe.sv
// Pipelined CORDIC vectoring/rotation core, NUM_STAGES+1 cycles latency, 1 beat/cycle.
// Whole pipe advances only when the output slot is empty or taken; in_ready mirrors that.
module cordic_vecrot_pipe
    import cordic_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int NUM_STAGES   = 16
) (
    input logic                 clk,
    input logic                 nreset,
    cordic_vecrot_pipe_if.slave bus
);

    localparam int W = CORDIC_WIDTH;
    localparam int N = NUM_STAGES;

    logic                adv;
    logic                vld_s  [N+1];
    logic                mode_s [N+1];
    logic signed [W-1:0] x_s    [N+1];
    logic signed [W-1:0] y_s    [N+1];
    logic [N:0]          dir_s  [N+1];

    logic                    flip;
    logic signed [SAT_W-1:0] x_ext;
    logic signed [SAT_W-1:0] y_ext;
    logic signed [W-1:0]     x0_d;
    logic signed [W-1:0]     y0_d;
    logic [N:0]              dir0_d;

    logic                vld0_q;
    logic                mode0_q;
    logic signed [W-1:0] x0_q;
    logic signed [W-1:0] y0_q;
    logic [N:0]          dir0_q;

    assign adv          = bus.out_ready | ~vld_s[N];
    assign bus.in_ready = adv;

    // Quadrant pre-correction: fold the left half-plane onto the right so the
    // micro stages only have to cover +/-99.9 degrees.
    always_comb begin
        x_ext  = {{(SAT_W-W){bus.x_in[W-1]}}, bus.x_in};
        y_ext  = {{(SAT_W-W){bus.y_in[W-1]}}, bus.y_in};
        flip   = (bus.mode_in == MODE_ROT) ? bus.dir_in[N] : bus.x_in[W-1];
        dir0_d = (bus.mode_in == MODE_ROT) ? bus.dir_in : {flip, {N{1'b0}}};
        x0_d   = bus.x_in;
        y0_d   = bus.y_in;
        if (flip) begin
            x0_d = W'(sat_neg(x_ext, W));
            y0_d = W'(sat_neg(y_ext, W));
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld0_q  <= 1'b0;
            mode0_q <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            dir0_q  <= '0;
        end else if (adv) begin
            vld0_q  <= bus.in_valid;
            mode0_q <= bus.mode_in;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            dir0_q  <= dir0_d;
        end
    end

    assign vld_s[0]  = vld0_q;
    assign mode_s[0] = mode0_q;
    assign x_s[0]    = x0_q;
    assign y_s[0]    = y0_q;
    assign dir_s[0]  = dir0_q;

    for (genvar i = 0; i < N; i++) begin : g_stage
        cordic_micro_stage #(
            .CORDIC_WIDTH (W),
            .SHIFT        (i),
            .NUM_STAGES   (N)
        ) u_stage (
            .clk    (clk),
            .nreset (nreset),
            .adv_i  (adv),
            .vld_i  (vld_s[i]),
            .mode_i (mode_s[i]),
            .x_i    (x_s[i]),
            .y_i    (y_s[i]),
            .dir_i  (dir_s[i]),
            .vld_o  (vld_s[i+1]),
            .mode_o (mode_s[i+1]),
            .x_o    (x_s[i+1]),
            .y_o    (y_s[i+1]),
            .dir_o  (dir_s[i+1])
        );
    end

    assign bus.out_valid = vld_s[N];
    assign bus.mode_out  = mode_s[N];
    assign bus.x_out     = x_s[N];
    assign bus.y_out     = y_s[N];
    assign bus.dir_out   = dir_s[N];

endmodule

// File: tb/tb_cordic_vecrot_pipe.sv
// Directed bench for cordic_vecrot_pipe: hand-derived vectors plus a small reference model.
module tb_cordic_vecrot_pipe;
    import cordic_pkg::*;

    localparam int     W    = 22;
    localparam int     N    = 16;
    localparam longint HALF = 64'sd1 <<< (W - 1);

    logic clk    = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    cordic_vecrot_pipe_if #(.CORDIC_WIDTH(W), .NUM_STAGES(N)) bus ();

    cordic_vecrot_pipe #(.CORDIC_WIDTH(W), .NUM_STAGES(N)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic signed [W-1:0] cap_x, cap_y, vec_x, vec_y;
    logic [N:0]          cap_dir, vec_dir, mdir;
    logic                cap_mode;
    longint              mx, my;
    int                  lat;
    int                  sent, rcvd, stall_left, cyc;
    bit                  stall_started;
    logic [63:0]         exp_q [$];
    logic [63:0]         obs_beat;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((2 * HALF) - 1);
        if (m >= HALF) m = m - 2 * HALF;
        return m;
    endfunction

    function automatic longint negsat(input longint v);
        if (v == -HALF) return HALF - 1;
        return wrapw(-v);
    endfunction

    // Reference: straight-line software CORDIC on 64-bit integers, wrapped to W bits per stage.
    task automatic model(input logic mode, input longint xi, input longint yi, input logic [N:0] di,
                         output longint xo, output longint yo, output logic [N:0] dout);
        longint x, y, xn, yn;
        logic   flip, d;
        dout = '0;
        flip = mode ? di[N] : (xi < 0);
        x = xi;
        y = yi;
        if (flip) begin
            x = negsat(x);
            y = negsat(y);
        end
        if (mode) dout = di;
        else      dout[N] = flip;
        for (int i = 0; i < N; i++) begin
            d = mode ? di[i] : (y < 0);
            if (!mode) dout[i] = d;
            if (d) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
            end
            x = wrapw(xn);
            y = wrapw(yn);
        end
        xo = x;
        yo = y;
    endtask

    // Send one beat into an idle pipe, wait for it, capture it, then let it drain.
    task automatic run_single(input logic mode, input longint xi, input longint yi, input logic [N:0] di);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.mode_in   = mode;
        bus.x_in      = W'(xi);
        bus.y_in      = W'(yi);
        bus.dir_in    = di;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        cap_x    = bus.x_out;
        cap_y    = bus.y_out;
        cap_dir  = bus.dir_out;
        cap_mode = bus.mode_out;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode_in   = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.dir_in    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2 nreset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_x_out", bus.x_out, 0);
        check("rst_y_out", bus.y_out, 0);
        check("rst_dir_out", bus.dir_out, 0);
        check("rst_mode_out", bus.mode_out, 0);
        #19 nreset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", bus.in_ready, 1);

        // Vectoring of (-1000, 0): flip, magnitude ~1000*K
        run_single(MODE_VEC, -1000, 0, '0);
        check("vec1_latency", lat, 17);
        check("vec1_flip", cap_dir[N], 1);
        check("vec1_x_window", (cap_x >= 1631 && cap_x <= 1663), 1);
        check("vec1_y_small", (cap_y >= -2 && cap_y <= 2), 1);
        model(MODE_VEC, -1000, 0, '0, mx, my, mdir);
        check("vec1_x_model", cap_x, mx);
        check("vec1_y_model", cap_y, my);
        check("vec1_dir_model", cap_dir, mdir);

        // Vectoring (3000,4000) then rotation replay with the produced word
        run_single(MODE_VEC, 3000, 4000, '0);
        vec_x   = cap_x;
        vec_y   = cap_y;
        vec_dir = cap_dir;
        check("vec2_mode", cap_mode, MODE_VEC);
        check("vec2_x_window", (cap_x >= 8218 && cap_x <= 8250), 1);
        model(MODE_VEC, 3000, 4000, '0, mx, my, mdir);
        check("vec2_x_model", cap_x, mx);
        check("vec2_dir_model", cap_dir, mdir);
        run_single(MODE_ROT, 3000, 4000, vec_dir);
        check("rot2_x_eq_vec", cap_x, vec_x);
        check("rot2_y_eq_vec", cap_y, vec_y);
        check("rot2_dir_pass", cap_dir, vec_dir);
        check("rot2_mode", cap_mode, MODE_ROT);

        // Rotation with all d=0 on (1024,0): hand-traced result
        run_single(MODE_ROT, 1024, 0, '0);
        check("rot3_x", cap_x, -297);
        check("rot3_y", cap_y, -1653);
        check("rot3_dir", cap_dir, 0);

        // Most negative x: pre-stage negate must saturate
        run_single(MODE_VEC, -HALF, 0, '0);
        model(MODE_VEC, -HALF, 0, '0, mx, my, mdir);
        check("sat_x_model", cap_x, mx);
        check("sat_y_model", cap_y, my);
        check("sat_dir_model", cap_dir, mdir);

        // 40 back-to-back mixed-mode beats, 5-cycle output stall at beat 20
        sent = 0; rcvd = 0; stall_left = 0; cyc = 0; stall_started = 0;
        while (rcvd < 40 && cyc < 400) begin
            if (sent == 20 && !stall_started) begin
                stall_started = 1;
                stall_left    = 5;
            end
            bus.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            bus.in_valid = (sent < 40);
            bus.mode_in  = sent[0];
            bus.x_in     = W'(1000 + 37 * sent);
            bus.y_in     = W'(500 - 23 * sent);
            bus.dir_in   = (N+1)'(sent * 2731);
            #1;
            check("stream_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                obs_beat = {2'b00, bus.mode_out, bus.dir_out, bus.x_out, bus.y_out};
                if (exp_q.size() == 0) check("stream_extra_beat", rcvd, -1);
                else                   check("stream_beat", obs_beat, exp_q.pop_front());
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.mode_in, longint'(bus.x_in), longint'(bus.y_in), bus.dir_in, mx, my, mdir);
                exp_q.push_back({2'b00, bus.mode_in, mdir, W'(mx), W'(my)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_rcvd", rcvd, 40);
        check("stream_sent", sent, 40);
        check("stream_stall_seen", stall_started, 1);

        // Fill the pipe, then reset asynchronously mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode_in   = MODE_ROT;
        bus.x_in      = 22'sd1234;
        bus.y_in      = -22'sd567;
        bus.dir_in    = 17'h0AAAA;
        repeat (20) @(posedge clk);
        #1;
        check("full_out_valid", bus.out_valid, 1);
        check("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_x_out", bus.x_out, 0);
        check("flush_y_out", bus.y_out, 0);
        check("flush_dir_out", bus.dir_out, 0);
        check("flush_mode_out", bus.mode_out, 0);
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;
        run_single(MODE_VEC, 700, 300, '0);
        check("post_rst_latency", lat, 17);
        model(MODE_VEC, 700, 300, '0, mx, my, mdir);
        check("post_rst_x", cap_x, mx);
        check("post_rst_y", cap_y, my);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_vecrot_pipe.md
# cordic_vecrot_pipe

Parametrised, fully pipelined CORDIC core performing either vectoring (drive y to zero, emit micro-rotation direction word) or rotation (apply a supplied direction word) per beat, with quadrant pre-correction and valid/ready backpressure. It is the Givens-rotation engine of the Simplex-FastICA datapath. A column pair is vectored once, and the resulting direction word is replayed in rotation mode on the companion vectors. No gain compensation is applied; downstream scaling absorbs K ≈ 1.6468.

## Interface
- CORDIC_WIDTH, 22, two's-complement width of x/y datapath.
- NUM_STAGES, 16, number of micro-rotation stages; stage i shifts by i (i = 0..NUM_STAGES-1).
- clk  in  1  clock; all state on rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  core can accept a beat this cycle.
- mode_in  in  1  0 = vectoring, 1 = rotation.
- x_in, y_in  in  CORDIC_WIDTH  signed input vector.
- dir_in  in  NUM_STAGES+1  rotation-mode direction word; bit NUM_STAGES = quadrant flip, bit i = stage i direction; ignored in vectoring.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- mode_out  out  1  mode of the output beat.
- x_out, y_out  out  CORDIC_WIDTH  signed result.
- dir_out  out  NUM_STAGES+1  vectoring: generated direction word; rotation: dir_in passed through.

## Operation
- Pipeline = 1 pre-stage + NUM_STAGES micro stages, each registered; each slot carries valid, mode, x, y, dir word.
- Pre-stage, vectoring: if x_in < 0, negate x and y, set dir[NUM_STAGES]=1; else pass, bit=0.
- Pre-stage, rotation: negate x and y iff dir_in[NUM_STAGES]=1.
- Negation saturates: -(-2^(W-1)) = 2^(W-1)-1.
- Stage i direction d: vectoring d = sign(y) (0 when y ≥ 0), written to dir[i]; rotation d = dir[i].
- d=0: x' = x + (y>>>i), y' = y - (x>>>i). d=1: x' = x - (y>>>i), y' = y + (x>>>i).
- Shifts are arithmetic (sign-extended) and truncating; adds wrap at CORDIC_WIDTH.
- No internal growth bits: caller keeps |x|,|y| ≤ 2^(W-1)/2.33; overflow beyond that wraps, unflagged.
- Vectoring then rotation of the same (x,y) with the produced dir word is bit-exact identical.
- Mode is per beat; mixed-mode streams are legal and order-preserving.

## Timing
- adv = out_ready | ~out_valid; in_ready = adv (combinational from out_ready and out_valid only).
- On adv: every slot loads from its predecessor; slot 0 loads input, with valid = in_valid. On ~adv: all slots hold.
- Bubbles are not compressed.
- Latency: NUM_STAGES+1 cycles from accepted beat to out_valid, given continuous adv.
- Throughput: 1 beat/cycle with out_ready held high.
- While out_valid & ~out_ready: outputs stable, in_ready = 0, no beat lost or duplicated.
- Reset values: all slot valids 0, all data/dir/mode 0; out_valid=0, x_out=y_out=0, dir_out=0, mode_out=0.
- Reset mid-operation flushes the pipeline asynchronously; in-flight beats are discarded.

## Structure
- Shared package cordic_pkg: MODE_VEC=1'b0, MODE_ROT=1'b1 constants; saturating-negate function.
- Sub-module cordic_micro_stage:
  - parameters CORDIC_WIDTH, SHIFT, NUM_STAGES.
  - one registered stage with adv enable, valid/mode/x/y/dir slot.
  - instantiated NUM_STAGES times via generate.
- Pre-stage and handshake logic live in the top module.

## Test plan
- Vectoring, W=22, N=16, x_in=-1000, y_in=0: out after 17 cycles has dir_out[16]=1, x_out within 1647±16, |y_out| ≤ 2.
- Vectoring of (3000,4000), then rotation of (3000,4000) with the captured dir_out: rotation x_out/y_out equal vectoring outputs bit-exact; x_out ≈ 8234±16.
- Rotation, dir_in=0, (x,y)=(1024,0): x_out/y_out match a software model of all-d=0 shifts exactly.
- x_in=-2^21 in vectoring: pre-stage x = 2^21-1, no wrap.
- 40 back-to-back beats, out_ready toggled 0 for 5 cycles at beat 20: all 40 emerge in order, no loss or duplication; in_ready=0 exactly while out_valid & ~out_ready.
- Pipeline full, nreset pulsed low: out_valid=0 and all outputs 0 immediately; first new beat appears 17 cycles after acceptance.
